// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the receiver state encoding, default framing constants and the
// command byte values exchanged with state_machine over the serial link.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 16;
    localparam int UART_DATA_BITS       = 8;

    // Command bytes understood by state_machine
    localparam logic [7:0] CMD_UART_TX = 8'h2A;
    localparam logic [7:0] CMD_UART_RX = 8'h45;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset, loads RESET_VAL into both flops
//   d     - asynchronous input
//   q     - synchronized output, two cycles behind d
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_reg <= RESET_VAL;
            sync_reg <= RESET_VAL;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/uart_receiver.sv
// 8N1-style UART receiver, LSB first, fixed oversampling.
// The start bit is re-checked half a bit after its falling edge; every
// following bit is then sampled one full bit later, i.e. at mid-bit.
// Ports:
//   clk       - system clock
//   reset     - synchronous active-high reset (discards a frame in progress)
//   rx        - asynchronous serial line, idle high
//   recv      - one-cycle strobe, uart_rx holds a newly received byte
//   uart_rx   - last correctly framed byte, held between strobes
//   frame_err - one-cycle strobe, stop bit was sampled low
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic                 recv,
    output logic [DATA_BITS-1:0] uart_rx,
    output logic                 frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    logic rx_s;

    rx_state_t            state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [DATA_BITS-1:0] uart_rx_reg, uart_rx_next;
    logic                 recv_reg, recv_next;
    logic                 frame_err_reg, frame_err_next;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            idx_reg       <= '0;
            shift_reg     <= '0;
            uart_rx_reg   <= '0;
            recv_reg      <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            idx_reg       <= idx_next;
            shift_reg     <= shift_next;
            uart_rx_reg   <= uart_rx_next;
            recv_reg      <= recv_next;
            frame_err_reg <= frame_err_next;
        end
    end

    // Next-state logic; the counter restarts on every state change
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + CNT_W'(1);
        idx_next   = idx_reg;
        shift_next = shift_reg;
        unique case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (!rx_s) begin
                    state_next = START;
                end
            end
            START: begin
                if (cnt_reg == HALF_LAST) begin
                    cnt_next   = '0;
                    idx_next   = '0;
                    // A line already back high at mid start bit was a glitch
                    state_next = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next   = '0;
                    // LSB arrives first, so new bits enter at the top
                    shift_next = DATA_BITS'({rx_s, shift_reg} >> 1);
                    if (idx_reg == IDX_LAST) begin
                        state_next = STOP;
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                    end
                end
            end
            STOP: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next   = '0;
                    state_next = rx_s ? IDLE : BREAK;
                end
            end
            BREAK: begin
                // Hold here while the line stays low so a break reports once
                cnt_next = '0;
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    // Output logic, registered above so both strobes are glitch-free
    always_comb begin
        recv_next      = 1'b0;
        frame_err_next = 1'b0;
        uart_rx_next   = uart_rx_reg;
        if (state_reg == STOP && cnt_reg == BIT_LAST) begin
            if (rx_s) begin
                recv_next    = 1'b1;
                uart_rx_next = shift_reg;
            end else begin
                frame_err_next = 1'b1;
            end
        end
    end

    assign recv      = recv_reg;
    assign uart_rx   = uart_rx_reg;
    assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: the serial driver pushes the expected
// strobe (kind, byte, cycle) for every frame; a negedge monitor pops and
// compares whenever recv or frame_err is high.
module tb_uart_receiver;

    localparam int N       = 16;
    localparam int LATENCY = 2 + 1 + N / 2 + 9 * N;  // pin edge to strobe cycle

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       rx;
    logic       recv;
    logic [7:0] uart_rx;
    logic       frame_err;

    int   tests_run;
    int   tests_failed;
    int   cyc;
    exp_t sb[$];
    logic [7:0] last_good;

    uart_receiver #(
        .CLKS_PER_BIT (N),
        .DATA_BITS    (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .recv      (recv),
        .uart_rx   (uart_rx),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("[TB] ok   %s: 0x%0h (cycle %0d)", name, act, cyc);
        end
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!reset && (recv || frame_err)) begin
            if (recv && frame_err) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL both_strobes: recv=%0b frame_err=%0b required not both", recv, frame_err);
            end
            if (sb.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected_strobe: recv=%0b frame_err=%0b uart_rx=0x%0h, none required (cycle %0d)",
                         recv, frame_err, uart_rx, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check(e.is_err ? "frame_err_kind" : "recv_kind", int'(frame_err), int'(e.is_err));
                check("uart_rx", int'(uart_rx), int'(e.data));
                check("strobe_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic hold(input logic b, input int cycles);
        rx = b;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Drives one full frame; expectation pushed at the start-bit edge
    task automatic send_frame(input logic [7:0] d, input logic stop);
        exp_t e;
        e.is_err = !stop;
        e.data   = stop ? d : last_good;
        e.cyc    = cyc + LATENCY;
        sb.push_back(e);
        if (stop) last_good = d;
        hold(1'b0, N);
        for (int i = 0; i < 8; i++) hold(d[i], N);
        hold(stop, N);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("queue_drained", sb.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;
        last_good    = 8'h00;
        rx           = 1'b1;
        reset        = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_recv", int'(recv), 0);
        check("reset_frame_err", int'(frame_err), 0);
        check("reset_uart_rx", int'(uart_rx), 0);
        @(posedge clk);
        #1;
        hold(1'b1, 2 * N);

        // 1: single frame
        send_frame(8'h2A, 1'b1);
        drain();

        // 2: back-to-back frames, no idle gap
        send_frame(8'h45, 1'b1);
        send_frame(8'hDE, 1'b1);
        drain();

        // 3: short glitch rejected, then a good frame
        hold(1'b0, 4);
        hold(1'b1, 3 * N);
        send_frame(8'h2A, 1'b1);
        drain();

        // 4: framing error keeps old byte, then recovery
        send_frame(8'h55, 1'b0);
        hold(1'b1, 2 * N);
        drain();
        send_frame(8'h11, 1'b1);
        drain();

        // 5: break condition, one frame_err only
        e.is_err = 1'b1;
        e.data   = last_good;
        e.cyc    = cyc + LATENCY;
        sb.push_back(e);
        hold(1'b0, 40 * N);
        hold(1'b1, 2 * N);
        drain();
        send_frame(8'hFF, 1'b1);
        drain();

        // 6: reset in the middle of DATA of 0xA5
        hold(1'b0, N);
        hold(1'b1, N);
        hold(1'b0, N);
        hold(1'b1, N / 2);
        reset = 1'b1;
        rx    = 1'b1;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        last_good = 8'h00;
        @(negedge clk);
        check("midreset_recv", int'(recv), 0);
        check("midreset_frame_err", int'(frame_err), 0);
        check("midreset_uart_rx", int'(uart_rx), 0);
        @(posedge clk);
        #1;
        hold(1'b1, 12 * N);
        send_frame(8'h3C, 1'b1);
        drain();
        hold(1'b1, 4 * N);
        check("final_uart_rx_held", int'(uart_rx), 8'h3C);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
